// File: rtl/proc_pkg.sv
// Shared definitions for the instruction fetch/issue slice: instruction
// width, field positions, opcode constants and the issue FSM state type.
package proc_pkg;

    localparam int INSTR_W = 34;

    // Field positions within an instruction word
    localparam int OP_MSB  = 33;
    localparam int OP_LSB  = 31;
    localparam int RS1_MSB = 30;
    localparam int RS1_LSB = 26;
    localparam int RS2_MSB = 25;
    localparam int RS2_LSB = 21;
    localparam int RD_MSB  = 20;
    localparam int RD_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Opcode constants
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LD  = 3'b101;
    localparam logic [2:0] OP_ST  = 3'b110;
    localparam logic [2:0] OP_BR  = 3'b111;

    // Issue FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        HALT  = 3'd4
    } state_e;

    // Extract the opcode field from an instruction word
    function automatic logic [2:0] instr_op(input logic [INSTR_W-1:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/instr_mem_sync.sv
// Program memory: DEPTH x W array with one write port and one synchronous
// read port (1-cycle latency). Contents are never reset.
// Optional macro ISSUE_PREFETCH_EN adds a second, enabled read port whose
// output register holds its value while the enable is low.
module instr_mem_sync #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 34
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
`ifdef ISSUE_PREFETCH_EN
    ,
    input  logic          re2,
    input  logic [AW-1:0] raddr2,
    output logic [W-1:0]  rdata2
`endif
);

    logic [W-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Primary synchronous read port (read-before-write on same address)
    always_ff @(posedge clk) begin
        rdata <= mem_r[raddr];
    end

`ifdef ISSUE_PREFETCH_EN
    // Prefetch read port; output holds when not enabled
    always_ff @(posedge clk) begin
        if (re2) begin
            rdata2 <= mem_r[raddr2];
        end
    end
`endif

endmodule

// File: rtl/instr_issue_unit.sv
// Instruction fetch and issue stage: loadable program memory, program
// counter and a FETCH/ISSUE/WAIT handshake with the downstream core.
// Optional macro ISSUE_PREFETCH_EN: reads mem[pc+1] while waiting so the
// next instruction issues one cycle after done instead of two.
module instr_issue_unit
    import proc_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int INSTR_W = proc_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_we,
    input  logic [AW-1:0]      load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [AW:0]        prog_len,
    input  logic               start,
    input  logic               done,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_en,
    output logic [AW-1:0]      pc,
    output logic               busy,
    output logic               halted,
    output logic [15:0]        issued_cnt
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [AW-1:0]      pc_r;
    logic [AW:0]        len_r;
    logic [INSTR_W-1:0] instr_r;
    logic               en_r;
    logic               busy_r;
    logic               halted_r;
    logic [15:0]        cnt_r;
    logic [AW:0]        len_clamp_s;
    logic               last_s;
    logic               idle_like_s;
    logic               mem_we_s;
    logic [INSTR_W-1:0] rdata_s;
    logic [INSTR_W-1:0] issue_word_s;

    assign idle_like_s = (state_r == IDLE) || (state_r == HALT);
    // Loads are only accepted while no program is running
    assign mem_we_s    = load_we && idle_like_s;
    // Final instruction of the current run
    assign last_s      = ({1'b0, pc_r} == (len_r - {{AW{1'b0}}, 1'b1}));

    // Clamp the requested program length to the memory depth
    always_comb begin
        if (prog_len > DEPTH_L) begin
            len_clamp_s = DEPTH_L;
        end else begin
            len_clamp_s = prog_len;
        end
    end

`ifdef ISSUE_PREFETCH_EN
    logic               pf_sel_r;
    logic               pf_re_s;
    logic [AW-1:0]      pf_addr_s;
    logic [INSTR_W-1:0] pf_rdata_s;

    assign pf_re_s   = (state_r == WAIT);
    assign pf_addr_s = pc_r + {{(AW-1){1'b0}}, 1'b1};

    // Remember whether ISSUE was entered straight from WAIT (prefetched word)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_sel_r <= 1'b0;
        end else begin
            pf_sel_r <= (state_r == WAIT) && done && !last_s;
        end
    end

    // Select the prefetched word when ISSUE follows a completed instruction
    always_comb begin
        if (pf_sel_r) begin
            issue_word_s = pf_rdata_s;
        end else begin
            issue_word_s = rdata_s;
        end
    end
`else
    assign issue_word_s = rdata_s;
`endif

    instr_mem_sync #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (INSTR_W)
    ) u_mem (
        .clk    (clk),
        .we     (mem_we_s),
        .waddr  (load_addr),
        .wdata  (load_data),
        .raddr  (pc_r),
        .rdata  (rdata_s)
`ifdef ISSUE_PREFETCH_EN
        ,
        .re2    (pf_re_s),
        .raddr2 (pf_addr_s),
        .rdata2 (pf_rdata_s)
`endif
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, HALT: begin
                if (start) begin
                    if (len_clamp_s == {(AW+1){1'b0}}) begin
                        state_nxt_s = HALT;
                    end else begin
                        state_nxt_s = FETCH;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            FETCH: state_nxt_s = ISSUE;
            ISSUE: state_nxt_s = WAIT;
            WAIT: begin
                if (done) begin
                    if (last_s) begin
                        state_nxt_s = HALT;
                    end else begin
`ifdef ISSUE_PREFETCH_EN
                        state_nxt_s = ISSUE;
`else
                        state_nxt_s = FETCH;
`endif
                    end
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath: pc, length, counter and instruction output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= '0;
            len_r   <= '0;
            cnt_r   <= 16'd0;
            instr_r <= '0;
            en_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE, HALT: begin
                    if (start) begin
                        pc_r  <= '0;
                        cnt_r <= 16'd0;
                        len_r <= len_clamp_s;
                    end
                end
                ISSUE: begin
                    instr_r <= issue_word_s;
                    en_r    <= 1'b1;
                end
                WAIT: begin
                    if (done) begin
                        en_r  <= 1'b0;
                        cnt_r <= cnt_r + 16'd1;
                        if (!last_s) begin
                            pc_r <= pc_r + {{(AW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    en_r <= en_r;
                end
            endcase
        end
    end

    // Registered status flags derived from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r   <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            busy_r   <= (state_nxt_s == FETCH) || (state_nxt_s == ISSUE) ||
                        (state_nxt_s == WAIT);
            halted_r <= (state_nxt_s == HALT);
        end
    end

    assign instr      = instr_r;
    assign instr_en   = en_r;
    assign pc         = pc_r;
    assign busy       = busy_r;
    assign halted     = halted_r;
    assign issued_cnt = cnt_r;

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed self-checking bench for instr_issue_unit. A small core model
// raises done a fixed number of cycles after instr_en; a per-cycle monitor
// checks issue order, pc, low gap between issues and counter behaviour.
// Optional macro ISSUE_PREFETCH_EN selects the 1-cycle inter-issue gap.
module tb_instr_issue_unit;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int IW    = 34;
`ifdef ISSUE_PREFETCH_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_we = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [IW-1:0] load_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          done = 1'b0;
    logic [IW-1:0] instr;
    logic          instr_en;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;
    logic [15:0]   issued_cnt;

    logic [IW-1:0] exp_mem [DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    instr_issue_unit #(.DEPTH(DEPTH), .AW(AW), .INSTR_W(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .prog_len   (prog_len),
        .start      (start),
        .done       (done),
        .instr      (instr),
        .instr_en   (instr_en),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] mk(input int op, input int a, input int b,
                                         input int d, input int imm);
        return {3'(op), 5'(a), 5'(b), 5'(d), 16'(imm)};
    endfunction

    task automatic load_word(input int addr, input logic [IW-1:0] data);
        load_we   = 1'b1;
        load_addr = 4'(addr);
        load_data = data;
        tick();
        load_we   = 1'b0;
        exp_mem[addr] = data;
    endtask

    // Start a run, play the core, and check each issue; optional disturbance
    // (start + write to addr 2 during WAIT) or async reset abort at an index.
    task automatic run_prog(input int len_in, input int n_exp, input int hold,
                            input int disturb, input int abort, input bit co_load);
        int idx = 0;
        int low = 0;
        int age = 0;
        int hold_left = 0;
        int budget = 0;
        int exp_gap;
        bit fin = 1'b0;
        bit aborted = 1'b0;
        logic prev_en = 1'b0;
        logic [15:0] prev_cnt = 16'd0;
        logic [AW-1:0] exp_pc;
        prog_len = 5'(len_in);
        start = 1'b1;
        if (co_load) begin
            load_we = 1'b1; load_addr = 4'd0; load_data = exp_mem[0];
        end
        while (!fin && budget < 400) begin
            tick();
            budget++;
            start = 1'b0;
            load_we = 1'b0;
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) done = 1'b0;
            end
            if (instr_en && !prev_en) begin
                exp_pc = 4'(idx);
                exp_gap = (idx == 0) ? 2 : GAP;
                n_checks++;
                if (instr !== exp_mem[idx]) begin
                    n_fail++;
                    $display("FAIL issue_instr[%0d]: got %h expected %h", idx, instr, exp_mem[idx]);
                end
                n_checks++;
                if (pc !== exp_pc) begin
                    n_fail++;
                    $display("FAIL issue_pc[%0d]: got %0d expected %0d", idx, pc, exp_pc);
                end
                n_checks++;
                if (low !== exp_gap) begin
                    n_fail++;
                    $display("FAIL issue_gap[%0d]: got %0d expected %0d", idx, low, exp_gap);
                end
                if (idx == disturb) begin
                    start = 1'b1; load_we = 1'b1; load_addr = 4'd2; load_data = ~exp_mem[2];
                end
                if (idx == abort) begin
                    rst_n = 1'b0;
                    #1;
                    n_checks++;
                    if (instr_en !== 1'b0 || pc !== 4'd0 || busy !== 1'b0 || issued_cnt !== 16'd0) begin
                        n_fail++;
                        $display("FAIL abort_reset: got en=%b pc=%0d busy=%b cnt=%0d expected 0 0 0 0",
                                 instr_en, pc, busy, issued_cnt);
                    end
                    done = 1'b0; start = 1'b0; load_we = 1'b0;
                    #3;
                    rst_n = 1'b1;
                    aborted = 1'b1;
                    fin = 1'b1;
                end
                idx++;
                age = 0;
                low = 0;
            end
            if (!aborted) begin
                if (!instr_en) low++;
                n_checks++;
                if (prev_en && !instr_en) begin
                    if (issued_cnt !== prev_cnt + 16'd1) begin
                        n_fail++;
                        $display("FAIL cnt_step: got %0d expected %0d", issued_cnt, prev_cnt + 16'd1);
                    end
                end else if (issued_cnt !== prev_cnt) begin
                    n_fail++;
                    $display("FAIL cnt_hold: got %0d expected %0d", issued_cnt, prev_cnt);
                end
                if (instr_en) begin
                    age++;
                    if (age == 3 && hold_left == 0) begin
                        done = 1'b1;
                        hold_left = hold;
                    end
                end
                if (halted) fin = 1'b1;
                prev_en = instr_en;
                prev_cnt = issued_cnt;
            end
        end
        done = 1'b0;
        n_checks++;
        if (!fin) begin
            n_fail++;
            $display("FAIL run_timeout: got no halt after %0d cycles expected halt", budget);
        end
        if (!aborted && fin) begin
            exp_pc = 4'(n_exp - 1);
            n_checks++;
            if (idx !== n_exp) begin
                n_fail++;
                $display("FAIL issue_count: got %0d expected %0d", idx, n_exp);
            end
            n_checks++;
            if (issued_cnt !== 16'(n_exp) || pc !== exp_pc || busy !== 1'b0 || instr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL run_end: got cnt=%0d pc=%0d busy=%b en=%b expected %0d %0d 0 0",
                         issued_cnt, pc, busy, instr_en, n_exp, exp_pc);
            end
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if (pc !== 4'd0 || instr !== '0 || instr_en !== 1'b0 || busy !== 1'b0 ||
            halted !== 1'b0 || issued_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: got pc=%0d instr=%h en=%b busy=%b halt=%b cnt=%0d expected all 0",
                     pc, instr, instr_en, busy, halted, issued_cnt);
        end
        #3;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b halted=%b expected 0 0", busy, halted);
        end
    endtask

    task automatic test_basic_run();
        load_word(0, mk(0, 0, 0, 1, 17));
        for (int i = 1; i < 9; i++) load_word(i, mk(i % 8, i, i + 1, i + 2, i * 100 + 17));
        run_prog(9, 9, 1, -1, -1, 1'b0);
        n_checks++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_halted: got %b expected 1", halted);
        end
    endtask

    task automatic test_zero_len();
        prog_len = 5'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || instr_en !== 1'b0 || issued_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL zero_len: got halt=%b busy=%b en=%b cnt=%0d expected 1 0 0 0",
                     halted, busy, instr_en, issued_cnt);
        end
        done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            done = 1'b0;
            n_checks++;
            if (instr_en !== 1'b0 || issued_cnt !== 16'd0 || halted !== 1'b1) begin
                n_fail++;
                $display("FAIL zero_len_idle[%0d]: got en=%b cnt=%0d halt=%b expected 0 0 1",
                         i, instr_en, issued_cnt, halted);
            end
        end
    endtask

    task automatic test_busy_ignore();
        run_prog(9, 9, 1, 0, -1, 1'b0);
    endtask

    task automatic test_abort_reset();
        run_prog(9, 9, 1, -1, 4, 1'b0);
        tick();
        run_prog(9, 9, 1, -1, -1, 1'b0);
    endtask

    task automatic test_done_held();
        run_prog(9, 9, 5, -1, -1, 1'b0);
    endtask

    task automatic test_len_clamp();
        for (int i = 1; i < 16; i++) load_word(i, mk(7 - (i % 8), 31 - i, i, 16 + i, 16'hA000 + i));
        exp_mem[0] = mk(3'd5, 5'd9, 5'd10, 5'd11, 16'h5A5A);
        run_prog(20, 16, 1, -1, -1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_zero_len();
        test_busy_ignore();
        test_abort_reset();
        test_done_held();
        test_len_clamp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
